instruction_loader: RTL and testbench

//  Write-side companion of the instruction memory: a boot-time program loader.

---
 rtl/instruction_loader_pkg.sv | 22 ++
 rtl/instruction_loader_if.sv | 28 ++
 rtl/instruction_loader_word_assembler.sv | 29 ++
 rtl/instruction_loader.sv | 126 ++++++++++++
 tb/tb_instruction_loader.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding and frame geometry.
package instruction_loader_pkg;

    localparam int BYTE_WIDTH = 8;
    localparam int HDR_BYTES  = 4;
    localparam int CHK_BYTES  = 1;
    localparam int WORD_WIDTH = BYTE_WIDTH * HDR_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WR,
        S_CHK,
        S_FIN
    } state_t;

    function automatic logic accepts_bytes(input state_t s);
        return s inside {S_HDR, S_DATA, S_CHK};
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream, memory-write and status signals of the program loader.
interface instruction_loader_if
    import instruction_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [BYTE_WIDTH-1:0] byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_data, busy, done, error
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_data, busy, done, error
    );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Big-endian byte-to-word shift register; last_byte flags that the next shift completes a word.
module word_assembler
    import instruction_loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  last_byte
);
    logic [1:0] idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word <= '0;
            idx  <= '0;
        end else if (clear) begin
            word <= '0;
            idx  <= '0;
        end else if (shift_en) begin
            word <= {word[WORD_WIDTH-BYTE_WIDTH-1:0], byte_in};
            idx  <= idx + 2'd1;
        end
    end

    assign last_byte = (idx == 2'(HDR_BYTES - 1));
endmodule

// File: rtl/instruction_loader.sv
// Boot loader: parses a {base,count,words,xor} byte frame and writes the words to instruction memory.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input logic                 clock,
    input logic                 reset,
    instruction_loader_if.slave bus
);
    state_t                state, state_next;
    logic                  asm_clear, asm_shift, last_byte, xfer;
    logic [WORD_WIDTH-1:0] word, word_full;
    logic [15:0]           hdr_base, hdr_count, count;
    logic [16:0]           hdr_end;
    logic                  hdr_bad;
    logic [BYTE_WIDTH-1:0] chk;
    logic                  byte_ready, mem_we, busy, done, error;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    word_assembler u_asm (
        .clock    (clock),
        .reset    (reset),
        .clear    (asm_clear),
        .shift_en (asm_shift),
        .byte_in  (bus.byte_in),
        .word     (word),
        .last_byte(last_byte)
    );

    // The word including the byte being accepted right now, so header/data act on the 4th byte's edge.
    assign xfer      = bus.byte_valid && byte_ready;
    assign word_full = {word[WORD_WIDTH-BYTE_WIDTH-1:0], bus.byte_in};
    assign hdr_base  = word_full[31:16];
    assign hdr_count = word_full[15:0];
    assign hdr_end   = {1'b0, hdr_base} + {1'b0, hdr_count};
    assign hdr_bad   = (hdr_end > 17'(MEM_DEPTH));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        asm_clear  = 1'b0;
        asm_shift  = 1'b0;
        case (state)
            S_IDLE: if (bus.start) begin
                state_next = S_HDR;
                asm_clear  = 1'b1;
            end
            S_HDR: if (xfer) begin
                asm_shift = 1'b1;
                if (last_byte) begin
                    if (hdr_bad)               state_next = S_FIN;
                    else if (hdr_count == '0)  state_next = S_CHK;
                    else                       state_next = S_DATA;
                end
            end
            S_DATA: if (xfer) begin
                asm_shift = 1'b1;
                if (last_byte) state_next = S_WR;
            end
            S_WR:    state_next = (count == 16'd1) ? S_CHK : S_DATA;
            S_CHK:   if (xfer) state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered decodes of the next state, so they track the state register exactly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            count      <= '0;
            chk        <= '0;
        end else begin
            byte_ready <= accepts_bytes(state_next);
            mem_we     <= (state_next == S_WR);
            busy       <= state_next inside {S_HDR, S_DATA, S_WR, S_CHK};
            done       <= (state_next == S_FIN);
            case (state)
                S_IDLE: if (bus.start) begin
                    error <= 1'b0;
                    chk   <= '0;
                end
                S_HDR: if (xfer && last_byte) begin
                    if (hdr_bad) begin
                        error <= 1'b1;
                    end else if (hdr_count != '0) begin
                        count    <= hdr_count;
                        mem_addr <= hdr_base[ADDR_WIDTH-1:0];
                    end
                end
                S_DATA: if (xfer) begin
                    chk <= chk ^ bus.byte_in;
                    if (last_byte) mem_data <= DATA_WIDTH'(word_full);
                end
                S_WR: begin
                    mem_addr <= mem_addr + ADDR_WIDTH'(1);
                    count    <= count - 16'd1;
                end
                S_CHK: if (xfer) error <= (bus.byte_in != chk);
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_data   = mem_data;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.error      = error;
endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: frame-level reference model feeds expected writes/results.
module tb_instruction_loader;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] fw [0:15];
    logic [9:0]  exp_addr [$];
    logic [31:0] exp_data [$];
    logic        exp_err  [$];

    instruction_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    instruction_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: actual event/timeout seen, required none", name);
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_byte_ready"}, 64'(bus.byte_ready), 64'(0));
        check({p, "_mem_we"},     64'(bus.mem_we),     64'(0));
        check({p, "_mem_addr"},   64'(bus.mem_addr),   64'(0));
        check({p, "_mem_data"},   64'(bus.mem_data),   64'(0));
        check({p, "_busy"},       64'(bus.busy),       64'(0));
        check({p, "_done"},       64'(bus.done),       64'(0));
        check({p, "_error"},      64'(bus.error),      64'(0));
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (bus.mem_we) begin
                    if (exp_addr.size() == 0) begin
                        note_fail("unexpected_write");
                    end else begin
                        check("wr_addr", 64'(bus.mem_addr), 64'(exp_addr.pop_front()));
                        check("wr_data", 64'(bus.mem_data), 64'(exp_data.pop_front()));
                    end
                end
                if (bus.done) begin
                    if (exp_err.size() == 0) begin
                        note_fail("unexpected_done");
                    end else begin
                        check("done_error", 64'(bus.error), 64'(exp_err.pop_front()));
                        check("done_busy",  64'(bus.busy),  64'(0));
                    end
                end
            end
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    // Optional random idle cycles (with stray start pulses), then hold the byte until accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                bus.start = ($urandom_range(0, 2) == 0);
                @(posedge clock); #1;
            end
            bus.start = 1'b0;
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clock);
            if (bus.byte_ready) break;
            n++;
            if (n > 50) begin
                note_fail("byte_accept_timeout");
                break;
            end
        end
        @(posedge clock); #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((bus.busy || bus.done) && n < 100);
        if (bus.busy || bus.done) note_fail("idle_timeout");
    endtask

    // Reference model: range check on base+count, writes at base+i, result error from XOR of data bytes.
    task automatic run_frame(input int base, input int count, input bit flip, input bit gaps);
        logic [7:0]  x, chk_byte;
        logic [15:0] b16, c16;
        logic [31:0] w;
        bit          bad;
        x   = 8'h00;
        b16 = 16'(base);
        c16 = 16'(count);
        bad = (base + count) > 1024;
        for (int i = 0; i < count; i++) begin
            w = fw[i];
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        chk_byte = flip ? (x ^ 8'h01) : x;
        if (!bad) begin
            for (int i = 0; i < count; i++) begin
                exp_addr.push_back(10'(base + i));
                exp_data.push_back(fw[i]);
            end
        end
        exp_err.push_back(bad || (chk_byte != x));

        pulse_start();
        send_byte(b16[15:8], gaps);
        send_byte(b16[7:0],  gaps);
        send_byte(c16[15:8], gaps);
        send_byte(c16[7:0],  gaps);
        if (!bad) begin
            for (int i = 0; i < count; i++) begin
                w = fw[i];
                for (int k = 0; k < 4; k++) send_byte(w[31 - 8*k -: 8], gaps);
            end
            send_byte(chk_byte, gaps);
        end
        wait_idle();
    endtask

    task automatic load_test1_words();
        fw[0] = 32'h8000_0019;
        fw[1] = 32'hC840_0000;
    endtask

    task automatic reset_mid_session();
        logic [31:0] w;
        load_test1_words();
        w = fw[0];
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(w[31 - 8*k -: 8], 1'b0);
        check("we_latency", 64'(bus.mem_we), 64'(1));
        check("we_addr", 64'(bus.mem_addr), 64'(5));
        #1 reset = 1'b1;
        #1 check_reset_vals("mid_rst");
        @(posedge clock); #2;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clock);
        #1 check_reset_vals("rst");
        reset = 1'b0;
        @(posedge clock); #1;

        load_test1_words();
        run_frame(5, 2, 1'b0, 1'b0);
        run_frame(5, 2, 1'b1, 1'b0);
        run_frame(1022, 3, 1'b0, 1'b0);
        run_frame(0, 0, 1'b0, 1'b0);
        run_frame(0, 0, 1'b1, 1'b0);
        run_frame(5, 2, 1'b0, 1'b1);
        run_frame(1020, 4, 1'b0, 1'b1);
        reset_mid_session();
        load_test1_words();
        run_frame(5, 2, 1'b0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            int cnt;
            int base;
            cnt = $urandom_range(0, 8);
            if ($urandom_range(0, 3) == 0) base = 1024 - cnt + $urandom_range(0, 2);
            else                           base = $urandom_range(0, 1023 - cnt);
            for (int i = 0; i < cnt; i++) fw[i] = $urandom();
            run_frame(base, cnt, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end

        repeat (5) @(negedge clock);
        check("writes_left", 64'(exp_addr.size()), 64'(0));
        check("results_left", 64'(exp_err.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
